branch_link_unit: RTL and testbench

- Parametrised branch-resolution and link-writeback unit for the MIPS pipeline.
- Evaluates the full signed branch set (beq, bne, blez, bgtz, bltz, bgez, bltzal, bgezal) on ID-stage operands.
- Registers the taken/redirect decision to the fetch stage.
- Carries link writes ($31 <- PC+8) through a DEPTH-stage shift pipeline to the register-file write port, honouring stall and flush.

---
 rtl/br_pkg.sv | 49 ++++
 rtl/branch_link_unit_link_pipe.sv | 53 +++++
 rtl/branch_link_unit.sv | 93 +++++++++
 tb/tb_branch_link_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared definitions for the branch/link unit.
//   br_op_e      4-bit branch opcode (OP_NONE .. OP_BGEZAL; 9-15 decode as NONE)
//   LINK_REG_DEFAULT  register written by the and-link branches ($31)
//   br_is_branch Returns 1 when an opcode is a real branch (1..8).
//   br_cond      Returns the signed branch condition for an opcode.
// Operands to br_cond are sign-extended to BR_MAX_W by the caller. Sign
// extension keeps both equality and sign intact, so one function serves any
// datapath width up to BR_MAX_W.
package br_pkg;

    typedef enum logic [3:0] {
        OP_NONE   = 4'd0,
        OP_BEQ    = 4'd1,
        OP_BNE    = 4'd2,
        OP_BLEZ   = 4'd3,
        OP_BGTZ   = 4'd4,
        OP_BLTZ   = 4'd5,
        OP_BGEZ   = 4'd6,
        OP_BLTZAL = 4'd7,
        OP_BGEZAL = 4'd8
    } br_op_e;

    localparam logic [4:0] LINK_REG_DEFAULT = 5'd31;
    localparam int         BR_MAX_W         = 64;

    function automatic logic br_is_branch(input logic [3:0] op);
        return (op >= OP_BEQ) && (op <= OP_BGEZAL);
    endfunction

    function automatic logic br_cond(input logic [3:0] op,
                                     input logic signed [BR_MAX_W-1:0] rs,
                                     input logic signed [BR_MAX_W-1:0] rt);
        logic c;
        c = 1'b0;
        case (op)
            OP_BEQ:    c = (rs == rt);
            OP_BNE:    c = (rs != rt);
            OP_BLEZ:   c = (rs <= 0);
            OP_BGTZ:   c = (rs > 0);
            OP_BLTZ,
            OP_BLTZAL: c = (rs < 0);
            OP_BGEZ,
            OP_BGEZAL: c = (rs >= 0);
            default:   c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/branch_link_unit_link_pipe.sv
// link_shift_pipe: stall-aware valid+data shift register carrying link writes
// from the branch decision to the register-file write port.
//   clk, rst_n    clock, asynchronous active-low reset
//   stall_i       hold every stage; input is ignored
//   in_valid_i    link write entering stage 0 (0 = bubble)
//   in_addr_i     destination register index
//   in_data_i     link value
//   out_*_o       contents of the last stage (DEPTH-1)
// Invalid entries are stored as all-zero, so the outputs read 0 whenever the
// last stage is empty without extra gating.
module link_shift_pipe #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             in_valid_i,
    input  logic [4:0]       in_addr_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    output logic [4:0]       out_addr_o,
    output logic [WIDTH-1:0] out_data_o
);

    logic [DEPTH-1:0] vld_q;
    logic [4:0]       addr_q [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (!stall_i) begin
            vld_q[0]  <= in_valid_i;
            addr_q[0] <= in_valid_i ? in_addr_i : '0;
            data_q[0] <= in_valid_i ? in_data_i : '0;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign out_valid_o = vld_q[DEPTH-1];
    assign out_addr_o  = addr_q[DEPTH-1];
    assign out_data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/branch_link_unit.sv
// branch_link_unit: resolves MIPS branches on ID-stage operands, registers
// the redirect to fetch, counts taken branches and carries $31 <- PC+8 link
// writes through a DEPTH-stage pipe to the register-file write port.
//   clk, rst_n         clock, asynchronous active-low reset
//   valid_i, stall_i, flush_i   ID handshake; stall holds everything
//   br_op_i            branch opcode (see br_pkg)
//   rs_i, rt_i         forwarded operands
//   pc_i, imm_i        branch PC and 16-bit offset
//   taken_o, target_o  registered redirect pulse and target
//   lw_en_o, lw_addr_o, lw_data_o   link writeback port
//   taken_cnt_o        saturating taken-branch count
module branch_link_unit
    import br_pkg::*;
#(
    parameter int         WIDTH       = 32,
    parameter int         DEPTH       = 3,
    parameter logic [4:0] LINK_REG    = LINK_REG_DEFAULT,
    parameter bit         LINK_ALWAYS = 1'b1,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [3:0]       br_op_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    input  logic [WIDTH-1:0] pc_i,
    input  logic [15:0]      imm_i,
    output logic             taken_o,
    output logic [WIDTH-1:0] target_o,
    output logic             lw_en_o,
    output logic [4:0]       lw_addr_o,
    output logic [WIDTH-1:0] lw_data_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    logic             acc;
    logic             cond;
    logic             take;
    logic             link_req;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] link_data;

    assign acc  = valid_i & ~flush_i & ~stall_i & br_is_branch(br_op_i);
    assign cond = br_cond(br_op_i, BR_MAX_W'($signed(rs_i)), BR_MAX_W'($signed(rt_i)));
    assign take = acc & cond;

    // Sum wraps modulo 2^WIDTH by construction.
    assign imm_ext   = WIDTH'($signed(imm_i));
    assign target    = pc_i + WIDTH'(4) + (imm_ext << 2);
    assign link_data = pc_i + WIDTH'(8);

    // MIPS and-link branches write $31 even when not taken unless
    // LINK_ALWAYS is cleared.
    assign link_req = acc & ((br_op_i == OP_BLTZAL) | (br_op_i == OP_BGEZAL))
                    & (LINK_ALWAYS | cond);

    // A pulse captured before a stall stays up until the stall releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_o     <= 1'b0;
            target_o    <= '0;
            taken_cnt_o <= '0;
        end else if (!stall_i) begin
            taken_o <= take;
            if (take) begin
                target_o <= target;
            end
            if (take && (taken_cnt_o != '1)) begin
                taken_cnt_o <= taken_cnt_o + CNT_W'(1);
            end
        end
    end

    link_shift_pipe #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_link_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_i     (stall_i),
        .in_valid_i  (link_req),
        .in_addr_i   (LINK_REG),
        .in_data_i   (link_data),
        .out_valid_o (lw_en_o),
        .out_addr_o  (lw_addr_o),
        .out_data_o  (lw_data_o)
    );

endmodule

// File: tb/tb_branch_link_unit.sv
// Two instances share one stimulus stream:
//   u0: defaults (DEPTH 3, LINK_ALWAYS 1, CNT_W 16)
//   u1: DEPTH 2, LINK_ALWAYS 0, CNT_W 2
module tb_branch_link_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] rs = '0, rt = '0, pc = '0;
    logic [15:0] imm = '0;

    logic        taken_w   [2];
    logic [31:0] target_w  [2];
    logic        lw_en_w   [2];
    logic [4:0]  lw_addr_w [2];
    logic [31:0] lw_data_w [2];
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    always #5 clk = ~clk;

    branch_link_unit u0 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid), .stall_i(stall), .flush_i(flush),
        .br_op_i(op), .rs_i(rs), .rt_i(rt), .pc_i(pc), .imm_i(imm),
        .taken_o(taken_w[0]), .target_o(target_w[0]), .lw_en_o(lw_en_w[0]),
        .lw_addr_o(lw_addr_w[0]), .lw_data_o(lw_data_w[0]), .taken_cnt_o(cnt0)
    );

    branch_link_unit #(.DEPTH(2), .LINK_ALWAYS(1'b0), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid), .stall_i(stall), .flush_i(flush),
        .br_op_i(op), .rs_i(rs), .rt_i(rt), .pc_i(pc), .imm_i(imm),
        .taken_o(taken_w[1]), .target_o(target_w[1]), .lw_en_o(lw_en_w[1]),
        .lw_addr_o(lw_addr_w[1]), .lw_data_o(lw_data_w[1]), .taken_cnt_o(cnt1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int k, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[u%0d]: got 0x%0h expected 0x%0h", name, k, got, exp);
        end
    endtask

    function automatic int dep(input int k);
        return (k == 0) ? 3 : 2;
    endfunction
    function automatic bit link_always(input int k);
        return k == 0;
    endfunction
    function automatic int cnt_max(input int k);
        return (k == 0) ? 65535 : 3;
    endfunction

    // Reference branch semantics straight from the ISA description.
    function automatic bit ref_cond(input logic [3:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
        int sa;
        sa = $signed(a);
        case (o)
            4'd1:       return a == b;
            4'd2:       return a != b;
            4'd3:       return sa <= 0;
            4'd4:       return sa > 0;
            4'd5, 4'd7: return sa < 0;
            4'd6, 4'd8: return sa >= 0;
            default:    return 1'b0;
        endcase
    endfunction

    // Reference model. Link writes go in a per-instance queue tagged with
    // the number of unstalled edges after which they must reach the port.
    typedef struct {
        int          due;
        logic [31:0] data;
    } link_t;

    link_t       lq [2][$];
    bit          m_taken  [2];
    logic [31:0] m_target [2];
    int          m_cnt    [2];
    int          shifts   [2];
    bit          cur_vld  [2];
    logic [31:0] cur_data [2];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    m_taken[k] = 0; m_target[k] = '0; m_cnt[k] = 0;
                    lq[k].delete(); cur_vld[k] = 0; cur_data[k] = '0;
                end
            end else if (!stall) begin
                for (int k = 0; k < 2; k++) begin
                    bit a, c, tk;
                    a  = valid && !flush && (op >= 4'd1) && (op <= 4'd8);
                    c  = ref_cond(op, rs, rt);
                    tk = a && c;
                    m_taken[k] = tk;
                    shifts[k]++;
                    if (tk) begin
                        m_target[k] = pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
                        if (m_cnt[k] < cnt_max(k)) m_cnt[k]++;
                    end
                    if (a && (op == 4'd7 || op == 4'd8) && (link_always(k) || c))
                        lq[k].push_back('{due: shifts[k] + dep(k) - 1, data: pc + 32'd8});
                    if (lq[k].size() > 0 && lq[k][0].due == shifts[k]) begin
                        link_t e;
                        e = lq[k].pop_front();
                        cur_vld[k]  = 1;
                        cur_data[k] = e.data;
                    end else begin
                        cur_vld[k]  = 0;
                        cur_data[k] = '0;
                    end
                end
            end
        end
    end

    // Monitor: compares every DUT output against the model on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check("taken_o", k, 64'(taken_w[k]), 64'(m_taken[k]));
                check("target_o", k, 64'(target_w[k]), 64'(m_target[k]));
                check("taken_cnt_o", k, (k == 0) ? 64'(cnt0) : 64'(cnt1), 64'(m_cnt[k]));
                check("lw_en_o", k, 64'(lw_en_w[k]), 64'(cur_vld[k]));
                check("lw_addr_o", k, 64'(lw_addr_w[k]), cur_vld[k] ? 64'd31 : 64'd0);
                check("lw_data_o", k, 64'(lw_data_w[k]), 64'(cur_data[k]));
            end
        end
    end

    // Drives one cycle's inputs and returns at the next falling edge, when the
    // outputs produced by those inputs are visible.
    task automatic cyc(input logic v, input logic s, input logic f, input logic [3:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [15:0] i);
        valid = v; stall = s; flush = f; op = o; rs = a; rt = b; pc = p; imm = i;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 4'd0, '0, '0, '0, '0);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // BEQ taken
        cyc(1, 0, 0, 4'd1, 32'h5, 32'h5, 32'h3000, 16'h0004);
        check("beq_taken", 0, 64'(taken_w[0]), 64'd1);
        check("beq_target", 0, 64'(target_w[0]), 64'h3014);
        idle(1);
        check("beq_pulse_end", 0, 64'(taken_w[0]), 64'd0);
        check("beq_cnt", 0, 64'(cnt0), 64'd1);

        // BLTZAL not taken: u0 links, u1 (LINK_ALWAYS 0) does not
        cyc(1, 0, 0, 4'd7, 32'h1, 32'h0, 32'h3008, 16'h0010);
        check("bltzal_nt", 0, 64'(taken_w[0]), 64'd0);
        idle(1);
        check("bltzal_early", 0, 64'(lw_en_w[0]), 64'd0);
        idle(1);
        check("bltzal_en", 0, 64'(lw_en_w[0]), 64'd1);
        check("bltzal_addr", 0, 64'(lw_addr_w[0]), 64'd31);
        check("bltzal_data", 0, 64'(lw_data_w[0]), 64'h3010);
        check("bltzal_la0", 1, 64'(lw_en_w[1]), 64'd0);

        // BGEZAL taken, stalled twice while in flight
        cyc(1, 0, 0, 4'd8, 32'h0, 32'h0, 32'h3100, 16'hFFFF);
        check("bgezal_target", 0, 64'(target_w[0]), 64'h3100);
        cyc(1, 1, 0, 4'd1, 32'h0, 32'h0, 32'h5000, 16'h0);
        cyc(0, 1, 0, 4'd0, 32'h0, 32'h0, 32'h0, 16'h0);
        check("stall_hold_pulse", 0, 64'(taken_w[0]), 64'd1);
        idle(2);
        check("bgezal_link_en", 0, 64'(lw_en_w[0]), 64'd1);
        check("bgezal_link_data", 0, 64'(lw_data_w[0]), 64'h3108);

        // Flush and stall+flush priority
        cyc(1, 0, 1, 4'd7, 32'hFFFF_FFFF, 32'h0, 32'h3200, 16'h1);
        cyc(1, 1, 1, 4'd7, 32'hFFFF_FFFF, 32'h0, 32'h3300, 16'h1);
        idle(4);

        // Wrap-around target and signed compare
        cyc(1, 0, 0, 4'd3, 32'h8000_0000, 32'h0, 32'hFFFF_FFF8, 16'h0002);
        check("wrap_taken", 0, 64'(taken_w[0]), 64'd1);
        check("wrap_target", 0, 64'(target_w[0]), 64'h4);

        // Counter saturation on the 2-bit instance
        cyc(1, 0, 0, 4'd1, 32'h7, 32'h7, 32'h100, 16'h1);
        cyc(1, 0, 0, 4'd2, 32'h7, 32'h8, 32'h200, 16'h1);
        check("cnt_total", 0, 64'(cnt0), 64'd5);
        check("cnt_saturate", 1, 64'(cnt1), 64'd3);

        // Reset one cycle after an accepted BGEZAL
        cyc(1, 0, 0, 4'd8, 32'h5, 32'h0, 32'h4000, 16'h0);
        valid = 0; op = 4'd0;
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_taken", k, 64'(taken_w[k]), 64'd0);
            check("rst_target", k, 64'(target_w[k]), 64'd0);
            check("rst_lw_en", k, 64'(lw_en_w[k]), 64'd0);
            check("rst_lw_data", k, 64'(lw_data_w[k]), 64'd0);
        end
        check("rst_cnt", 0, 64'(cnt0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, b;
            a = pick_val();
            b = ($urandom_range(0, 2) == 0) ? a : pick_val();
            cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2,
                $urandom_range(0, 19) < 3, 4'($urandom_range(0, 15)),
                a, b, $urandom & 32'hFFFF_FFFC, 16'($urandom));
        end
        idle(6);
        for (int k = 0; k < 2; k++)
            check("link_drained", k, 64'(lq[k].size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
